// File: rtl/sma_channel_scheduler.sv
// Round-robin scheduler sharing one moving-average engine (ring + running sum + restoring divider).
// Optional build macro SMA_WARMUP_EN: emit only once a channel's window has been filled.
module sma_channel_scheduler #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int WINDOW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req_valid,
  input  logic [N_CH*DATA_W-1:0]  req_data,
  output logic [N_CH-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  output logic                    busy
);
  localparam int CH_W   = $clog2(N_CH);
  localparam int SUM_W  = DATA_W + $clog2(WINDOW);
  localparam int PTR_W  = $clog2(WINDOW);
  localparam int FILL_W = $clog2(WINDOW + 1);
  localparam int CNT_W  = $clog2(SUM_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       rr_ptr_q;
  logic [CH_W-1:0]       grant_q;
  logic [DATA_W-1:0]     data_q;
  logic [SUM_W-1:0]      div_q;
  logic [SUM_W-1:0]      rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [CH_W-1:0]       out_ch_q;
  logic                  busy_q;

  logic [DATA_W-1:0]     ring_q [N_CH][WINDOW];
  logic [SUM_W-1:0]      sum_q  [N_CH];
  logic [PTR_W-1:0]      wptr_q [N_CH];
  logic [FILL_W-1:0]     fill_q [N_CH];

  logic [DATA_W-1:0]     req_words_s [N_CH];
  logic [N_CH-1:0]       rot_s;
  logic                  grant_found_s;
  logic [CH_W-1:0]       offs_s;
  logic [CH_W:0]         gsum_s;
  logic [CH_W-1:0]       grant_idx_s;
  logic [CH_W-1:0]       rr_next_s;
  logic [DATA_W-1:0]     old_s;
  logic [SUM_W-1:0]      sum_new_s;
  logic [PTR_W-1:0]      wptr_next_s;
  logic [FILL_W-1:0]     fill_next_s;
  logic [SUM_W:0]        rem_shift_s;
  logic [SUM_W-1:0]      rem_sub_s;
  logic [SUM_W-1:0]      rem_next_s;
  logic                  q_bit_s;
  logic [SUM_W-1:0]      div_next_s;
  logic                  div_last_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_words
    assign req_words_s[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the grant offset.
  assign rot_s = N_CH'({req_valid, req_valid} >> rr_ptr_q);

  // Priority search over the rotated request vector.
  always_comb begin
    grant_found_s = 1'b0;
    offs_s        = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      grant_found_s = grant_found_s | rot_s[k];
      offs_s        = rot_s[k] ? CH_W'(k) : offs_s;
    end
  end

  assign gsum_s      = {1'b0, rr_ptr_q} + {1'b0, offs_s};
  assign grant_idx_s = (gsum_s >= (CH_W+1)'(N_CH)) ? CH_W'(gsum_s - (CH_W+1)'(N_CH))
                                                   : gsum_s[CH_W-1:0];
  assign rr_next_s   = (grant_idx_s == CH_W'(N_CH - 1)) ? '0 : grant_idx_s + CH_W'(1);

  // Window update: the evicted slot is zero until the ring has wrapped once.
  assign old_s       = ring_q[grant_q][wptr_q[grant_q]];
  assign sum_new_s   = sum_q[grant_q] + SUM_W'(data_q) - SUM_W'(old_s);
  assign wptr_next_s = (wptr_q[grant_q] == PTR_W'(WINDOW - 1)) ? '0
                                                               : wptr_q[grant_q] + PTR_W'(1);
  assign fill_next_s = (fill_q[grant_q] == FILL_W'(WINDOW)) ? fill_q[grant_q]
                                                            : fill_q[grant_q] + FILL_W'(1);

  // One restoring-division step; quotient bits shift into div_q as the dividend shifts out.
  assign rem_shift_s = {rem_q, div_q[SUM_W-1]};
  assign q_bit_s     = rem_shift_s >= (SUM_W+1)'(WINDOW);
  assign rem_sub_s   = rem_shift_s[SUM_W-1:0] - SUM_W'(WINDOW);
  assign rem_next_s  = q_bit_s ? rem_sub_s : rem_shift_s[SUM_W-1:0];
  assign div_next_s  = {div_q[SUM_W-2:0], q_bit_s};
  assign div_last_s  = (cnt_q == CNT_W'(SUM_W - 1));

  // Next-state and accept-strobe logic.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_d   = ST_UPDATE;
          req_ready = {{(N_CH-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
`ifdef SMA_WARMUP_EN
        if (fill_next_s < FILL_W'(WINDOW)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIVIDE;
        end
`else
        state_d = ST_DIVIDE;
`endif
      end
      ST_DIVIDE: begin
        if (div_last_s) begin
          state_d = ST_EMIT;
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, channel bookkeeping, divider and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
        for (int w = 0; w < WINDOW; w++) begin
          ring_q[c][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (grant_found_s) begin
            grant_q  <= grant_idx_s;
            data_q   <= req_words_s[grant_idx_s];
            rr_ptr_q <= rr_next_s;
          end
        end
        ST_UPDATE: begin
          sum_q[grant_q]                  <= sum_new_s;
          ring_q[grant_q][wptr_q[grant_q]] <= data_q;
          wptr_q[grant_q]                 <= wptr_next_s;
          fill_q[grant_q]                 <= fill_next_s;
          div_q                           <= sum_new_s;
          rem_q                           <= '0;
          cnt_q                           <= '0;
        end
        ST_DIVIDE: begin
          div_q <= div_next_s;
          rem_q <= rem_next_s;
          cnt_q <= cnt_q + CNT_W'(1);
          if (div_last_s) begin
            out_valid_q <= 1'b1;
            out_data_q  <= div_next_s[DATA_W-1:0];
            out_ch_q    <= grant_q;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sma_channel_scheduler.sv
// Bench for sma_channel_scheduler: spec-constant vector table, directed corner sequences,
// and randomized traffic checked by a queue-based windowed-average and round-robin model.
module tb_sma_channel_scheduler;
  localparam int N_CH   = 4;
  localparam int DW     = 8;
  localparam int WINDOW = 5;
  localparam int SUM_W  = 11;
  localparam int CH_W   = 2;
  localparam int LAT    = SUM_W + 2;

  logic                 clk;
  logic                 rst;
  logic [N_CH-1:0]      req_valid;
  logic [N_CH*DW-1:0]   req_data;
  logic [N_CH-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int gorder[8];
  int gcount;

  sma_channel_scheduler #(.N_CH(N_CH), .DATA_W(DW), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < N_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: last WINDOW samples per channel, rr pointer, engine-occupied flag.
  int  hist[N_CH][$];
  int  m_rr = 0;
  bit  m_pend = 0;
  int  m_wait = 0;
  int  m_exp_d = 0;
  int  m_exp_c = 0;

  always @(negedge clk) begin : mon
    logic [N_CH-1:0] er;
    int g;
    int s;
    bit ev;
    if (rst) begin
      m_rr = 0; m_pend = 0; m_wait = 0;
      for (int c = 0; c < N_CH; c++) hist[c].delete();
    end else begin
      if (m_pend && m_wait > 0) m_wait--;
      ev = m_pend && (m_wait == 0);
      chk("mon_out_valid", out_valid, ev);
      if (ev) begin
        chk("mon_out_data", out_data, m_exp_d);
        chk("mon_out_ch", out_ch, m_exp_c);
      end
      chk("mon_busy", busy, m_pend);
      er = '0;
      g  = -1;
      if (!m_pend)
        for (int k = N_CH - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % N_CH]) g = (m_rr + k) % N_CH;
      if (g >= 0) er[g] = 1'b1;
      chk("mon_req_ready", req_ready, er);
      if (ev && out_ready) m_pend = 0;
      if (g >= 0) begin
        hist[g].push_back(int'(req_data[g*DW +: DW]));
        if (hist[g].size() > WINDOW) void'(hist[g].pop_front());
        s = 0;
        for (int i = 0; i < hist[g].size(); i++) s += hist[g][i];
        m_exp_d = s / WINDOW;
        m_exp_c = g;
        m_pend  = 1;
        m_wait  = LAT;
        m_rr    = (g + 1) % N_CH;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_one(input int ch, input int d, output int od, output int och, output int lat);
    int n;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_data[ch*DW +: DW] = d[DW-1:0];
    #1;
    n = 0;
    while (req_ready[ch] !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_accept", req_ready[ch], 1);
    @(posedge clk); #1;
    req_valid = '0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("send_out_valid", out_valid, 1);
    od = out_data;
    och = out_ch;
    @(posedge clk); #1;
  endtask

  task automatic collect_grants(input logic [N_CH-1:0] vmask, input bit keep, input int nwant);
    logic [N_CH-1:0] gr;
    gcount = 0;
    req_valid = vmask;
    for (int cyc = 0; cyc < 400 && gcount < nwant; cyc++) begin
      #1;
      gr = req_ready;
      if (gr != '0) begin
        chk("grant_onehot", $onehot(gr), 1);
        gorder[gcount] = onehot_idx(gr);
        gcount++;
      end
      @(posedge clk); #1;
      if (!keep) req_valid = req_valid & ~gr;
    end
    chk("grant_count", gcount, nwant);
    req_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = '0;
    out_ready = 1'b1;
    while ((busy !== 1'b0 || out_valid !== 1'b0) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_idle", busy, 0);
  endtask

  typedef struct { int ch; int data; int exp_avg; } vec_t;
  vec_t vecs[11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int od, och, lat, n, hd, hc;
    vecs[0]  = '{0, 10, 2};   vecs[1]  = '{0, 20, 6};   vecs[2]  = '{0, 30, 12};
    vecs[3]  = '{0, 40, 20};  vecs[4]  = '{0, 50, 30};  vecs[5]  = '{0, 60, 40};
    vecs[6]  = '{1, 255, 51}; vecs[7]  = '{1, 255, 102}; vecs[8] = '{1, 255, 153};
    vecs[9]  = '{1, 255, 204}; vecs[10] = '{1, 255, 255};

    req_data = '0;
    do_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);

    // Window fill, wrap/eviction, and full-scale samples.
    for (int i = 0; i < 11; i++) begin
      send_one(vecs[i].ch, vecs[i].data, od, och, lat);
      chk("vec_out_data", od, vecs[i].exp_avg);
      chk("vec_out_ch", och, vecs[i].ch);
      chk("vec_latency", lat, LAT);
    end

    // All channels requesting: strict rotation from rr_ptr=0.
    do_reset();
    for (int c = 0; c < N_CH; c++) req_data[c*DW +: DW] = 8'((c + 1) * 10);
    collect_grants(4'b1111, 1'b1, 5);
    chk("rr_order0", gorder[0], 0);
    chk("rr_order1", gorder[1], 1);
    chk("rr_order2", gorder[2], 2);
    chk("rr_order3", gorder[3], 3);
    chk("rr_order4", gorder[4], 0);
    drain();

    // Output back-pressure holds EMIT and blocks every requester.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[0 +: DW] = 8'd100;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_accept", req_ready[0], 1);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_data[DW +: DW] = 8'd50;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    hd = out_data;
    hc = out_ch;
    chk("bp_data", hd, 20);
    chk("bp_ch", hc, 0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid_held", out_valid, 1);
      chk("bp_data_held", out_data, 20);
      chk("bp_ch_held", out_ch, 0);
      chk("bp_no_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_released", out_valid, 0);
    chk("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    drain();

    // Lone requester wins regardless of rr_ptr; then ch3 before ch1 from rr_ptr=3.
    do_reset();
    send_one(2, 5, od, och, lat);
    chk("lone_first_data", od, 1);
    send_one(2, 10, od, och, lat);
    chk("lone_again_ch", och, 2);
    chk("lone_again_data", od, 3);
    collect_grants(4'b1010, 1'b0, 2);
    chk("rr3_first", gorder[0], 3);
    chk("rr3_second", gorder[1], 1);
    drain();

    // Reset while dividing discards the sample and clears all sums.
    do_reset();
    req_valid = 4'b0001;
    req_data[0 +: DW] = 8'd40;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_accept", req_ready[0], 1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy_after", busy, 0);
    chk("abort_valid_after", out_valid, 0);
    send_one(0, 25, od, och, lat);
    chk("abort_restart_data", od, 5);
    chk("abort_restart_ch", och, 0);

    // Randomized traffic, back-pressure and one mid-run reset against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = N_CH'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = 4'b0001 << $urandom_range(0, 3);
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst = (i == 1500);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
